regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with per-register pending-write scoreboard
// Register 0 is hardwired to zero; pending counters gate issue against RAW/WAW hazards.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NR-1:0]        rd_en_i,
  input  logic [NR*AW-1:0]     rs_i,
  output logic [NR*DATA_W-1:0] rdata_o,
  input  logic [NW-1:0]        wb_en_i,
  input  logic [NW*AW-1:0]     wb_addr_i,
  input  logic [NW*DATA_W-1:0] wb_data_i,
  input  logic [NW-1:0]        wb_clr_i,
  input  logic                 iss_valid_i,
  input  logic                 iss_we_i,
  input  logic [AW-1:0]        iss_rd_i,
  output logic                 iss_ready_o,
  output logic [NREGS-1:0]     busy_o,
  output logic                 err_o
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs     [NREGS];
  logic [PEND_W-1:0] pend     [NREGS];
  logic [PEND_W-1:0] pend_nxt [NREGS];
  int                clr_cnt  [NREGS];
  logic [NREGS-1:0]  under;
  logic              hazard;
  logic              fire;

  // Number of write ports retiring a reservation on each register this cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      clr_cnt[r] = 0;
      for (int w = 0; w < NW; w++) begin
        if (wb_en_i[w] && wb_clr_i[w] && r != 0 && wb_addr_i[w*AW +: AW] == AW'(r))
          clr_cnt[r] += 1;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd;
      ra = rs_i[p*AW +: AW];
      rd = regs[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (wb_en_i[w] && wb_addr_i[w*AW +: AW] != '0 && wb_addr_i[w*AW +: AW] == ra)
            rd = wb_data_i[w*DATA_W +: DATA_W];
        end
      end
      if (ra == '0)
        rd = '0;
      rdata_o[p*DATA_W +: DATA_W] = rd;
    end
  end

  // A pending source is no hazard when forwarding is on and this cycle's clears drain it.
  always_comb begin
    hazard = 1'b0;
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] ra;
      ra = rs_i[p*AW +: AW];
      if (rd_en_i[p] && ra != '0 && pend[ra] != '0) begin
        if (!(BYPASS != 0 && clr_cnt[ra] >= int'(pend[ra])))
          hazard = 1'b1;
      end
    end
  end

  assign iss_ready_o = !hazard && !(iss_we_i && pend[iss_rd_i] == PEND_MAX);
  assign fire        = iss_valid_i && iss_ready_o && iss_we_i && iss_rd_i != '0;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      int nxt;
      nxt = int'(pend[r]) - clr_cnt[r];
      if (fire && iss_rd_i == AW'(r))
        nxt += 1;
      under[r]    = nxt < 0;
      pend_nxt[r] = under[r] ? '0 : PEND_W'(nxt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      busy_o <= '0;
      err_o  <= 1'b0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins.
      for (int w = 0; w < NW; w++) begin
        if (wb_en_i[w] && wb_addr_i[w*AW +: AW] != '0)
          regs[wb_addr_i[w*AW +: AW]] <= wb_data_i[w*DATA_W +: DATA_W];
      end
      for (int r = 0; r < NREGS; r++) begin
        pend[r]   <= pend_nxt[r];
        busy_o[r] <= pend_nxt[r] != '0;
      end
      err_o <= err_o | (|under);
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed bench for regfile_sb with a behavioural scoreboard model
// Inputs change 1 time unit after posedge; the model is compared on every negedge.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int PMAX = 3;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rd_en;
  logic [9:0]    rs;
  logic [63:0]   rdata;
  logic [1:0]    wb_en;
  logic [9:0]    wb_addr;
  logic [63:0]   wb_data;
  logic [1:0]    wb_clr;
  logic          iss_valid;
  logic          iss_we;
  logic [4:0]    iss_rd;
  logic          iss_ready;
  logic [31:0]   busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [NREGS];
  int            m_pend [NREGS];
  logic          m_err;

  regfile_sb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_en_i(rd_en), .rs_i(rs), .rdata_o(rdata),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_valid_i(iss_valid), .iss_we_i(iss_we), .iss_rd_i(iss_rd),
    .iss_ready_o(iss_ready), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int waddr(int w);
    return int'(wb_addr[w*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] m_read(int p);
    int a;
    logic [DW-1:0] v;
    a = int'(rs[p*AW +: AW]);
    if (a == 0) return '0;
    v = m_regs[a];
    for (int w = 0; w < 2; w++)
      if (wb_en[w] && waddr(w) == a) v = wb_data[w*DW +: DW];
    return v;
  endfunction

  function automatic int m_clears(int a);
    int n = 0;
    for (int w = 0; w < 2; w++)
      if (wb_en[w] && wb_clr[w] && waddr(w) == a && a != 0) n++;
    return n;
  endfunction

  function automatic logic m_ready();
    logic ok = 1'b1;
    for (int p = 0; p < 2; p++) begin
      int a = int'(rs[p*AW +: AW]);
      if (rd_en[p] && a != 0 && m_pend[a] > 0 && m_clears(a) < m_pend[a]) ok = 1'b0;
    end
    if (iss_we && m_pend[int'(iss_rd)] == PMAX) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    for (int r = 0; r < NREGS; r++) b[r] = m_pend[r] != 0;
    return b;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endtask

  always @(negedge rst_n) m_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      m_clear();
    end else begin
      int cnt [NREGS];
      logic fire;
      fire = iss_valid && m_ready() && iss_we && iss_rd != 0;
      for (int r = 0; r < NREGS; r++) cnt[r] = m_pend[r] - m_clears(r);
      if (fire) cnt[int'(iss_rd)]++;
      for (int w = 0; w < 2; w++)
        if (wb_en[w] && waddr(w) != 0) m_regs[waddr(w)] = wb_data[w*DW +: DW];
      for (int r = 0; r < NREGS; r++) begin
        if (cnt[r] < 0) begin
          m_err = 1'b1;
          cnt[r] = 0;
        end
        m_pend[r] = cnt[r];
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (rd_en[p]) chk($sformatf("rdata%0d", p), 64'(rdata[p*DW +: DW]), 64'(m_read(p)));
    chk("iss_ready", 64'(iss_ready), 64'(m_ready()));
    chk("busy", 64'(busy), 64'(m_busy()));
    chk("err", 64'(err), 64'(m_err));
  end

  task automatic idle();
    rd_en = '0; rs = '0; wb_en = '0; wb_addr = '0; wb_data = '0; wb_clr = '0;
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0;
  endtask

  task automatic set_rd(int p, int a);
    rd_en[p] = 1'b1;
    rs[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wb(int w, int a, logic [DW-1:0] d, logic c);
    wb_en[w] = 1'b1;
    wb_addr[w*AW +: AW] = AW'(a);
    wb_data[w*DW +: DW] = d;
    wb_clr[w] = c;
  endtask

  task automatic set_iss(logic we, int a);
    iss_valid = 1'b1;
    iss_we = we;
    iss_rd = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic look();
    #3;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #4;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_ready", 64'(iss_ready), 64'h1);
    rst_n = 1'b1;
    tick();

    set_wb(0, 5, 32'hDEADBEEF, 1'b0);
    tick();
    set_rd(1, 5); set_wb(0, 0, 32'h1234, 1'b0);
    look(); chk("x5_read", 64'(rdata[63:32]), 64'hDEADBEEF);
    tick();
    set_rd(0, 0);
    look(); chk("x0_read", 64'(rdata[31:0]), 64'h0); chk("x0_busy", 64'(busy[0]), 64'h0);
    tick();

    set_wb(0, 7, 32'h11, 1'b0); set_wb(1, 7, 32'h22, 1'b0); set_rd(0, 7);
    look(); chk("x7_bypass", 64'(rdata[31:0]), 64'h22);
    tick();
    set_rd(0, 7);
    look(); chk("x7_stored", 64'(rdata[31:0]), 64'h22);
    tick();

    set_iss(1'b1, 3);
    look(); chk("x3_issue", 64'(iss_ready), 64'h1);
    tick();
    set_iss(1'b0, 0); set_rd(0, 3);
    look(); chk("x3_busy", 64'(busy[3]), 64'h1); chk("raw_stall", 64'(iss_ready), 64'h0);
    tick();
    set_iss(1'b0, 0); set_rd(0, 3); set_wb(0, 3, 32'hAB, 1'b1);
    look(); chk("raw_release", 64'(iss_ready), 64'h1); chk("x3_fwd", 64'(rdata[31:0]), 64'hAB);
    tick();
    look(); chk("x3_idle", 64'(busy[3]), 64'h0);
    tick();

    repeat (3) begin
      set_iss(1'b1, 9);
      look(); chk("x9_issue", 64'(iss_ready), 64'h1);
      tick();
    end
    set_iss(1'b1, 9);
    look(); chk("x9_sat", 64'(iss_ready), 64'h0);
    tick();
    set_iss(1'b1, 9); set_wb(0, 9, 32'h5, 1'b1);
    look(); chk("x9_sat_clr", 64'(iss_ready), 64'h0);
    tick();
    set_iss(1'b1, 9); set_wb(0, 9, 32'h6, 1'b1);
    look(); chk("x9_net", 64'(iss_ready), 64'h1);
    tick();
    set_iss(1'b1, 9);
    look(); chk("x9_refill", 64'(iss_ready), 64'h1);
    tick();
    set_iss(1'b1, 9);
    look(); chk("x9_sat2", 64'(iss_ready), 64'h0);
    tick();
    set_wb(0, 9, 32'h7, 1'b1); set_wb(1, 9, 32'h8, 1'b1);
    tick();
    look(); chk("x9_after2", 64'(busy[9]), 64'h1);
    set_wb(0, 9, 32'h9, 1'b1);
    tick();
    look(); chk("x9_drained", 64'(busy[9]), 64'h0); chk("no_err", 64'(err), 64'h0);
    tick();

    set_wb(1, 4, 32'h44, 1'b1);
    tick();
    look(); chk("underflow", 64'(err), 64'h1);
    tick(); tick();
    look(); chk("err_sticky", 64'(err), 64'h1);
    set_iss(1'b1, 10);
    tick();
    set_iss(1'b1, 11);
    tick();
    look(); chk("x10_x11_busy", 64'(busy[11:10]), 64'h3);
    set_rd(0, 5); set_rd(1, 7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_err", 64'(err), 64'h0);
    chk("mid_rst_x5", 64'(rdata[31:0]), 64'h0);
    chk("mid_rst_x7", 64'(rdata[63:32]), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    set_rd(0, 5); set_rd(1, 9);
    look(); chk("post_rst_x5", 64'(rdata[31:0]), 64'h0); chk("post_rst_x9", 64'(rdata[63:32]), 64'h0);
    tick();
    set_wb(0, 10, 32'h1, 1'b1);
    tick();
    look(); chk("stale_clr_err", 64'(err), 64'h1); chk("stale_clr_busy", 64'(busy), 64'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
